// File: rtl/word_store_unit_pkg.sv
// Shared definitions for the word store unit: FSM encoding and default address width.
package word_store_unit_pkg;

    localparam int ADDR_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } ws_state_e;

endpackage

// File: rtl/word_store_unit.sv
// Splits a 16-bit store request into two byte writes (low byte first) on an 8-bit memory port.
//
// state | meaning
// IDLE  | ready for a request, memory port quiet
// WR_LO | low byte presented at captured address, waiting for MemAck
// WR_HI | high byte presented at captured address + 1, waiting for MemAck
module word_store_unit
    import word_store_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              Clock,
    input  logic              ResetN,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [15:0]       ReqData,
    output logic              MemWE,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [7:0]        MemData,
    input  logic              MemAck,
    output logic              Busy,
    output logic              Done
);

    ws_state_e         state;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       data_q;

    // All outputs are registered alongside the state so they change only with it.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state    <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            MemWE    <= 1'b0;
            MemAddr  <= '0;
            MemData  <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            ReqReady <= 1'b1;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        state    <= WR_LO;
                        addr_q   <= ReqAddr;
                        data_q   <= ReqData;
                        MemWE    <= 1'b1;
                        MemAddr  <= ReqAddr;
                        MemData  <= ReqData[7:0];
                        Busy     <= 1'b1;
                        ReqReady <= 1'b0;
                    end
                end
                WR_LO: begin
                    if (MemAck) begin
                        state   <= WR_HI;
                        // Address wraps silently at the top of the space.
                        MemAddr <= addr_q + ADDR_W'(1);
                        MemData <= data_q[15:8];
                    end
                end
                WR_HI: begin
                    if (MemAck) begin
                        state    <= IDLE;
                        MemWE    <= 1'b0;
                        MemAddr  <= '0;
                        MemData  <= '0;
                        Busy     <= 1'b0;
                        Done     <= 1'b1;
                        ReqReady <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    MemWE    <= 1'b0;
                    MemAddr  <= '0;
                    MemData  <= '0;
                    Busy     <= 1'b0;
                    ReqReady <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/word_store_unit.md
WORD_STORE_UNIT -- requirements
Module: word_store_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the memory address width in bits.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port Clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port ResetN  input  1  asynchronous, active-low reset.
REQ-005 Port ReqValid  input  1  a store request is presented.
REQ-006 Port ReqReady  output  1  the block can accept a request this cycle.
REQ-007 Port ReqAddr  input  ADDR_W  byte address for the low byte.
REQ-008 Port ReqData  input  16  word to store.
REQ-009 Port MemWE  output  1  byte write strobe to memory.
REQ-010 Port MemAddr  output  ADDR_W  byte write address.
REQ-011 Port MemData  output  8  byte write data.
REQ-012 Port MemAck  input  1  memory accepts the presented byte this cycle.
REQ-013 Port Busy  output  1  a store is in progress.
REQ-014 Port Done  output  1  one-cycle pulse; the word store is complete.

Function
REQ-015 The block SHALL implement the FSM states IDLE, WR_LO and WR_HI.
REQ-016 Acceptance occurs when ReqValid and ReqReady are both 1 at a rising edge; ReqAddr and ReqData are captured into internal registers at that edge, and the state moves IDLE -> WR_LO.
REQ-017 ReqReady SHALL be 1 exactly when the state is IDLE; ReqValid in any other state SHALL be ignored.
REQ-018 In WR_LO the outputs SHALL be MemWE=1, MemAddr=captured address and MemData=captured data[7:0], all held stable until MemAck=1.
REQ-019 WR_LO with MemAck=1 SHALL transition to WR_HI.
REQ-020 In WR_HI the outputs SHALL be MemWE=1, MemAddr=(captured address+1) mod 2^ADDR_W and MemData=captured data[15:8], all held until MemAck=1.
REQ-021 Address wrap: a captured address of all-ones SHALL produce a high-byte address of 0, with no flag.
REQ-022 WR_HI with MemAck=1 SHALL transition to IDLE, and Done SHALL be 1 for exactly the following cycle.
REQ-023 MemAck SHALL be ignored while MemWE=0.
REQ-024 Busy SHALL equal (state != IDLE).
REQ-025 In IDLE, MemWE, MemAddr and MemData SHALL be 0.
REQ-026 Latency with MemAck held at 1: accept at edge T; low byte presented in cycle T+1; high byte presented in T+2; Done=1 and ReqReady=1 in T+3.
REQ-027 Each byte SHALL stay presented for the full cycle in which MemAck=1 is sampled, and for no additional cycle.
REQ-028 Back-to-back requests: a request presented while Done=1 SHALL be accepted in that same cycle, with no bubble beyond the IDLE cycle.
REQ-029 MemWE SHALL never be 1 for two different byte addresses within one cycle, and the block SHALL NOT write either byte twice.

Reset
REQ-030 While ResetN=0 the block SHALL asynchronously force: state=IDLE, captured registers=0, and the outputs MemWE=0, MemAddr=0, MemData=0, Busy=0, Done=0, ReqReady=1.
REQ-031 A reset during WR_LO or WR_HI SHALL abort the store without generating a Done pulse; a byte already acknowledged remains written.
REQ-032 After ResetN is released, the first rising edge SHALL be able to accept a request.

Structure
REQ-033 The FSM state encoding (IDLE=2'd0, WR_LO=2'd1, WR_HI=2'd2) SHALL reside in the shared CPU package.
REQ-034 ADDR_W SHALL be a module parameter, and its default SHALL be taken from the package address-width constant.
REQ-035 The block SHALL be a single module with no sub-modules; the byte mux and address incrementer SHALL be inline.

Verification
REQ-036 Basic store: ReqAddr=8'h10, ReqData=16'hBEEF, MemAck held 1 -> byte 8'hEF written at address 8'h10 in T+1, byte 8'hBE written at 8'h11 in T+2, Done pulses in T+3.
REQ-037 Stall: MemAck=0 for 3 cycles in WR_LO, then 1 -> low byte held unchanged for 4 cycles, high byte follows, exactly one Done pulse.
REQ-038 Wrap: ReqAddr=8'hFF, ReqData=16'h1234 -> byte 8'h34 written at 8'hFF, then 8'h12 at 8'h00.
REQ-039 Back-to-back: two requests (8'h20/16'hAAAA, 8'h40/16'h5555) with ReqValid held -> second request accepted in the Done cycle; memory sequence 20,21,40,41; two Done pulses.
REQ-040 Reset abort: ResetN driven low during WR_HI -> MemWE=0 immediately (asynchronously), no Done, ReqReady=1; a new request afterwards completes normally.
REQ-041 Ignore: ReqValid toggled with new data while Busy=1, and MemAck pulsed while in IDLE -> the stored bytes come only from the captured request, and no spurious write occurs.
